// File: rtl/lycan_globals.sv
// lycan_globals -- shared widths and types for the Lycan USB peripheral bridge.
//   usb_packet_width     : width of one word on the USB transmit path
//   periph_address_width : width of the peripheral address field carried in a word
//   lycan_rx_arb_state_t : state type of the peripheral RX arbiter
//   rr_next_index()      : wrap-around successor of a round-robin index
package lycan_globals;

  localparam int usb_packet_width     = 32;
  localparam int periph_address_width = 8;

  typedef enum logic [0:0] {
    RX_ARB_IDLE  = 1'b0,
    RX_ARB_BURST = 1'b1
  } lycan_rx_arb_state_t;

  function automatic int unsigned rr_next_index(input int unsigned idx,
                                                input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select -- combinational round-robin selector with a priority class.
//   req   : request vector (all candidates)
//   pri   : priority vector; if any requesting bit is also set here, only those
//           bits compete
//   start : index at which the circular search begins
//   valid : at least one request present
//   index : first competing bit found at or after start (wrapping)
module rr_priority_select
  import lycan_globals::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     pri,
  input  logic [IDX_W-1:0] start,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [N-1:0] hot;
  logic [N-1:0] cand;
  logic         found;
  int           pos;

  always_comb begin
    hot   = pri & req;
    cand  = (|hot) ? hot : req;
    valid = |req;
    index = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      if (!found && cand[pos]) begin
        index = IDX_W'(pos);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_rx_arbiter.sv
// periph_rx_arbiter -- drains peripheral RX FIFOs in bursts onto the USB transmit path.
//   clk, rst               : clock (rising edge), asynchronous active-high reset
//   periph_rx_data         : flattened per-peripheral FIFO read data, valid 1 cycle after read
//   periph_rx_empty        : per-peripheral FIFO empty
//   periph_rx_almost_full  : per-peripheral FIFO almost full (raises selection priority)
//   periph_ready           : peripheral may be accessed
//   periph_rx_read         : one-hot read strobe
//   out_data, out_valid    : word to the USB transmit path, held until accepted
//   out_ready              : downstream accepts when out_valid is high
//   grant_id               : current / most recent granted peripheral
//   busy                   : bursting or words still buffered
module periph_rx_arbiter
  import lycan_globals::*;
#(
  parameter int NUM_PERIPHS = 8,
  parameter int BURST_MAX   = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PERIPHS*usb_packet_width-1:0] periph_rx_data,
  input  logic [NUM_PERIPHS-1:0]                 periph_rx_empty,
  input  logic [NUM_PERIPHS-1:0]                 periph_rx_almost_full,
  input  logic [NUM_PERIPHS-1:0]                 periph_ready,
  output logic [NUM_PERIPHS-1:0]                 periph_rx_read,
  output logic [usb_packet_width-1:0]            out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$clog2(NUM_PERIPHS)-1:0]         grant_id,
  output logic                                   busy
);

  localparam int                IDX_W    = $clog2(NUM_PERIPHS);
  localparam int                CNT_W    = $clog2(BURST_MAX + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PERIPHS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_MAX - 1);

  lycan_rx_arb_state_t state_q, state_d;

  logic [IDX_W-1:0]            last_grant;
  logic [CNT_W-1:0]            burst_cnt;
  logic [NUM_PERIPHS-1:0]      eligible;
  logic                        sel_valid;
  logic [IDX_W-1:0]            sel_idx;
  logic [IDX_W-1:0]            sel_start;
  logic                        gnt_empty;
  logic                        gnt_ready;
  logic                        rd_en;
  logic                        room;
  logic [2:0]                  lvl;
  logic                        push;
  logic                        pop;

  // read issued last cycle; data arrives this cycle
  logic                        rd_vld_p1;
  logic [IDX_W-1:0]            rd_idx_p1;

  // two-entry output buffer
  logic [usb_packet_width-1:0] buf_mem [0:1];
  logic                        wr_ptr;
  logic                        rd_ptr;
  logic [1:0]                  occ;

  assign eligible  = periph_ready & ~periph_rx_empty;
  assign sel_start = IDX_W'(rr_next_index(32'(last_grant), NUM_PERIPHS));

  rr_priority_select #(
    .N     (NUM_PERIPHS),
    .IDX_W (IDX_W)
  ) u_select (
    .req   (eligible),
    .pri   (periph_rx_almost_full),
    .start (sel_start),
    .valid (sel_valid),
    .index (sel_idx)
  );

  assign gnt_empty = periph_rx_empty[last_grant];
  assign gnt_ready = periph_ready[last_grant];
  assign pop       = out_valid & out_ready;
  assign push      = rd_vld_p1;

  // Words already committed (buffered + in flight) minus the one leaving this
  // cycle must leave a free slot for the word a new read would return.
  assign lvl  = {1'b0, occ} + {2'b00, rd_vld_p1};
  assign room = pop ? (lvl < 3'd3) : (lvl < 3'd2);

  assign rd_en = (state_q == RX_ARB_BURST) && !gnt_empty && gnt_ready &&
                 (burst_cnt < CNT_MAX) && room;

  always_comb begin
    periph_rx_read = '0;
    if (rd_en) begin
      periph_rx_read[last_grant] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_ARB_IDLE: begin
        if (sel_valid) begin
          state_d = RX_ARB_BURST;
        end
      end
      RX_ARB_BURST: begin
        if (rd_en && (burst_cnt == CNT_LAST)) begin
          state_d = RX_ARB_IDLE;
        end else if (!rd_en && (gnt_empty || !gnt_ready || (burst_cnt >= CNT_MAX))) begin
          state_d = RX_ARB_IDLE;
        end
      end
      default: state_d = RX_ARB_IDLE;
    endcase
  end

  // Stage p0 -> p1: FSM, grant, burst counter, read tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RX_ARB_IDLE;
      last_grant <= LAST_IDX;
      burst_cnt  <= '0;
      rd_vld_p1  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_vld_p1 <= rd_en;
      if ((state_q == RX_ARB_IDLE) && sel_valid) begin
        last_grant <= sel_idx;
        burst_cnt  <= '0;
      end else if (rd_en) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_idx_p1 <= last_grant;
    end
  end

  // Stage p1 -> p2: capture returned word into the output buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[wr_ptr] <= periph_rx_data[int'(rd_idx_p1)*usb_packet_width +: usb_packet_width];
    end
  end

  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? buf_mem[rd_ptr] : '0;
  assign grant_id  = last_grant;
  assign busy      = (state_q == RX_ARB_BURST) || (occ != 2'd0);

endmodule

// File: doc/periph_rx_arbiter.md
PERIPH_RX_ARBITER -- requirements
Module: periph_rx_arbiter

Interface
REQ-001 Parameter NUM_PERIPHS, default 8: number of peripheral RX FIFOs arbitrated.
REQ-002 Parameter BURST_MAX, default 16: maximum words read per grant.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 periph_rx_data  input  NUM_PERIPHS x usb_packet_width  per-peripheral RX FIFO read data (valid 1 cycle after read).
REQ-006 periph_rx_empty  input  NUM_PERIPHS  per-peripheral RX FIFO empty.
REQ-007 periph_rx_almost_full  input  NUM_PERIPHS  per-peripheral RX FIFO almost full.
REQ-008 periph_ready  input  NUM_PERIPHS  peripheral out of post-reset no-access window.
REQ-009 periph_rx_read  output  NUM_PERIPHS  one-hot read strobe to peripheral RX FIFOs.
REQ-010 out_data  output  usb_packet_width  word to USB transmit path.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts; transfer when out_valid and out_ready.
REQ-013 grant_id  output  $clog2(NUM_PERIPHS)  index of current/last granted peripheral.
REQ-014 busy  output  1  high in BURST or while output buffer non-empty.

Function
REQ-015 Eligible(i) = periph_ready[i] and not periph_rx_empty[i].
REQ-016 States: IDLE, BURST; IDLE -> BURST when any peripheral eligible; BURST -> IDLE on burst end.
REQ-017 Selection in IDLE: if any eligible peripheral has almost_full high, pick among those only; else among all eligible.
REQ-018 Within the selected class, round-robin starting at index last_grant+1 modulo NUM_PERIPHS; last_grant resets to NUM_PERIPHS-1 (first search starts at 0).
REQ-019 Selected index registered into grant_id and last_grant on IDLE->BURST; no read issued in the IDLE cycle.
REQ-020 BURST: periph_rx_read[grant_id] high in a cycle iff granted FIFO not empty, periph_ready high, word count < BURST_MAX, and output buffer has room for the word after pops.
REQ-021 Never more than one periph_rx_read bit high; never read an empty or not-ready FIFO.
REQ-022 Read data captured from periph_rx_data[grant_id] exactly 1 cycle after the read strobe into a 2-entry output buffer.
REQ-023 Room rule: occupancy + in-flight read - (out_valid and out_ready) < 2; sustains 1 word/cycle when out_ready held high.
REQ-024 Burst ends (-> IDLE) when word count reaches BURST_MAX or granted FIFO is empty/not-ready with no read issued; word count clears on entry to BURST.
REQ-025 In-flight word from the final read is still captured after BURST->IDLE; next grant may start immediately.
REQ-026 out_data/out_valid driven from buffer head; out_data passed unmodified (address field already in word); order preserved.
REQ-027 out_valid, once high, stays high with out_data stable until accepted.
REQ-028 Outputs after reset: periph_rx_read 0, out_valid 0, out_data 0, grant_id NUM_PERIPHS-1, busy 0.

Reset
REQ-029 rst asynchronously clears state to IDLE, buffer, in-flight flag, counter, last_grant; buffered words discarded.
REQ-030 Reset mid-burst: read strobes drop immediately; no partial word emitted after release.

Structure
REQ-031 usb_packet_width and periph_address_width come from lycan_globals; state enum type lycan_rx_arb_state_t added there.
REQ-032 Selection logic as sub-module rr_priority_select (request vector, priority vector, start index -> valid, index), purely combinational.
REQ-033 Output buffer inline; no vendor FIFO IP.

Verification
REQ-034 Single peripheral 0, 3 words 0x01..03 queued, out_ready=1 -> out_data 0x01,0x02,0x03 on consecutive cycles, 3 read strobes, grant_id 0.
REQ-035 Peripherals 1,2,5 each 20 words, BURST_MAX=16 -> bursts ordered 1(16),2(16),5(16),1(4),2(4),5(4).
REQ-036 Peripheral 3 almost_full, 0 and 6 non-empty in IDLE -> grant_id 3 selected first.
REQ-037 out_ready=0 during burst -> at most 2 words buffered, reads stall, out_data stable; resume with no loss/duplication.
REQ-038 periph_ready[4]=0 with data queued -> periph_rx_read[4] never asserted until ready rises.
REQ-039 rst pulsed mid-burst with 2 words buffered -> out_valid 0 same cycle, no stale words after release.
